// File: rtl/instr_enc_pkg.sv
// Shared types and RV32I encoding constants for the instruction-memory loader.
package instr_enc_pkg;

   // Compact command opcodes accepted from the host
   typedef enum logic [1:0] {
      OP_ADDI = 2'b00,
      OP_LW   = 2'b01,
      OP_SW   = 2'b10,
      OP_BNE  = 2'b11
   } cmd_op_e;

   // RV32I major opcodes
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // RV32I funct3 fields for the supported instructions
   localparam logic [2:0] F3_ADDI = 3'b000;
   localparam logic [2:0] F3_LW   = 3'b010;
   localparam logic [2:0] F3_SW   = 3'b010;
   localparam logic [2:0] F3_BNE  = 3'b001;

   // Loader sequencing states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENC,
      ST_WR,
      ST_DONE,
      ST_FULL
   } loader_state_e;

endpackage

// File: rtl/rv_instr_encode.sv
// Purely combinational RV32I encoder for the addi/lw/sw/bne subset.
module rv_instr_encode
   import instr_enc_pkg::*;
(
   input  cmd_op_e     i_op,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [12:0] i_imm,
   output logic [31:0] o_word
);

   // Pack the instruction fields; imm[12] only matters for bne, imm[0] is dropped for bne
   always_comb begin
      o_word = '0;
      case (i_op)
         OP_ADDI: o_word = {i_imm[11:0], i_rs1, F3_ADDI, i_rd, OPC_OPIMM};
         OP_LW:   o_word = {i_imm[11:0], i_rs1, F3_LW, i_rd, OPC_LOAD};
         OP_SW:   o_word = {i_imm[11:5], i_rs2, i_rs1, F3_SW, i_imm[4:0], OPC_STORE};
         OP_BNE:  o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BNE,
                            i_imm[4:1], i_imm[11], OPC_BRANCH};
         default: o_word = '0;
      endcase
   end

endmodule

// File: rtl/instr_mem_loader.sv
// Accepts compact instruction commands, encodes them to RV32I and writes them
// to consecutive instruction-memory addresses, one word every three cycles.
module instr_mem_loader
   import instr_enc_pkg::*;
#(
   parameter int Wid    = 32,
   parameter int ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic [1:0]        i_cmd_op,
   input  logic [4:0]        i_cmd_rd,
   input  logic [4:0]        i_cmd_rs1,
   input  logic [4:0]        i_cmd_rs2,
   input  logic [12:0]       i_cmd_imm,
   input  logic              i_cmd_last,
   input  logic              i_restart,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [Wid-1:0]    o_mem_wdata,
   output logic [ADDR_W:0]   o_count,
   output logic              o_done,
   output logic              o_err_full,
   output logic              o_err_align
);

   loader_state_e       r_state;
   cmd_op_e             r_op;
   logic [4:0]          r_rd;
   logic [4:0]          r_rs1;
   logic [4:0]          r_rs2;
   logic [12:0]         r_imm;
   logic                r_last;
   logic                r_cmd_ready;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [Wid-1:0]      r_mem_wdata;
   logic [ADDR_W:0]     r_count;
   logic                r_done;
   logic                r_err_full;
   logic                r_err_align;
   logic [31:0]         w_enc_word;

   rv_instr_encode u_encode (
      .i_op   (r_op),
      .i_rd   (r_rd),
      .i_rs1  (r_rs1),
      .i_rs2  (r_rs2),
      .i_imm  (r_imm),
      .o_word (w_enc_word)
   );

   // Loader FSM: capture command, encode, write one word, then advance or stop
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state     <= ST_IDLE;
         r_op        <= OP_ADDI;
         r_rd        <= '0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_imm       <= '0;
         r_last      <= 1'b0;
         r_cmd_ready <= 1'b1;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_count     <= '0;
         r_done      <= 1'b0;
         r_err_full  <= 1'b0;
         r_err_align <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_cmd_valid && r_cmd_ready) begin
                  r_op        <= cmd_op_e'(i_cmd_op);
                  r_rd        <= i_cmd_rd;
                  r_rs1       <= i_cmd_rs1;
                  r_rs2       <= i_cmd_rs2;
                  r_imm       <= i_cmd_imm;
                  r_last      <= i_cmd_last;
                  r_cmd_ready <= 1'b0;
                  r_state     <= ST_ENC;
               end
            end
            ST_ENC: begin
               r_mem_wdata <= Wid'(w_enc_word);
               if (r_op == OP_BNE && r_imm[0]) begin
                  r_err_align <= 1'b1;
               end
               r_mem_we <= 1'b1;
               r_state  <= ST_WR;
            end
            ST_WR: begin
               r_mem_we <= 1'b0;
               r_count  <= r_count + 1'b1;
               if (r_last) begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else if (r_mem_addr == {ADDR_W{1'b1}}) begin
                  r_err_full <= 1'b1;
                  r_state    <= ST_FULL;
               end else begin
                  r_mem_addr  <= r_mem_addr + 1'b1;
                  r_cmd_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            ST_DONE, ST_FULL: begin
               if (i_restart) begin
                  r_mem_addr  <= '0;
                  r_count     <= '0;
                  r_done      <= 1'b0;
                  r_err_full  <= 1'b0;
                  r_err_align <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_cmd_ready <= 1'b1;
               r_mem_we    <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_cmd_ready = r_cmd_ready;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_count     = r_count;
   assign o_done      = r_done;
   assign o_err_full  = r_err_full;
   assign o_err_align = r_err_align;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader: a full-size instance for
// encoding/sequencing and a 4-word instance for the memory-full path.
module tb_instr_mem_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: ADDR_W = 8
   logic        rstA, validA, lastA, restartA;
   logic [1:0]  opA;
   logic [4:0]  rdA, rs1A, rs2A;
   logic [12:0] immA;
   logic        readyA, weA, doneA, errFullA, errAlignA;
   logic [7:0]  addrA;
   logic [31:0] wdataA;
   logic [8:0]  countA;

   // Instance B: ADDR_W = 2
   logic        rstB, validB, lastB, restartB;
   logic [1:0]  opB;
   logic [4:0]  rdB, rs1B, rs2B;
   logic [12:0] immB;
   logic        readyB, weB, doneB, errFullB, errAlignB;
   logic [1:0]  addrB;
   logic [31:0] wdataB;
   logic [2:0]  countB;

   int totalChecks = 0;
   int badChecks   = 0;

   instr_mem_loader #(.Wid(32), .ADDR_W(8)) dutA (
      .i_clk(clk), .i_rst(rstA), .i_cmd_valid(validA), .o_cmd_ready(readyA),
      .i_cmd_op(opA), .i_cmd_rd(rdA), .i_cmd_rs1(rs1A), .i_cmd_rs2(rs2A),
      .i_cmd_imm(immA), .i_cmd_last(lastA), .i_restart(restartA),
      .o_mem_we(weA), .o_mem_addr(addrA), .o_mem_wdata(wdataA), .o_count(countA),
      .o_done(doneA), .o_err_full(errFullA), .o_err_align(errAlignA)
   );

   instr_mem_loader #(.Wid(32), .ADDR_W(2)) dutB (
      .i_clk(clk), .i_rst(rstB), .i_cmd_valid(validB), .o_cmd_ready(readyB),
      .i_cmd_op(opB), .i_cmd_rd(rdB), .i_cmd_rs1(rs1B), .i_cmd_rs2(rs2B),
      .i_cmd_imm(immB), .i_cmd_last(lastB), .i_restart(restartB),
      .o_mem_we(weB), .o_mem_addr(addrB), .o_mem_wdata(wdataB), .o_count(countB),
      .o_done(doneB), .o_err_full(errFullB), .o_err_align(errAlignB)
   );

   // Advance to just after the next rising edge
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Send one command and capture what the write cycle shows
   task automatic applyStimulus(input bit useB, input logic [1:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [12:0] imm, input logic last,
                                output logic sawWe, output logic [7:0] sawAddr,
                                output logic [31:0] sawData);
      int waitCnt = 0;
      while (((useB ? readyB : readyA) !== 1'b1) && waitCnt < 20) begin
         stepCycle();
         waitCnt++;
      end
      totalChecks++;
      if (waitCnt >= 20) begin
         badChecks++;
         $display("[TB] FAIL ready_wait: got ready=0 after %0d cycles, required ready=1", waitCnt);
      end
      if (useB) begin
         opB = op; rdB = rd; rs1B = rs1; rs2B = rs2; immB = imm; lastB = last; validB = 1'b1;
      end else begin
         opA = op; rdA = rd; rs1A = rs1; rs2A = rs2; immA = imm; lastA = last; validA = 1'b1;
      end
      stepCycle();
      validA = 1'b0;
      validB = 1'b0;
      stepCycle();
      sawWe   = useB ? weB : weA;
      sawAddr = useB ? {6'd0, addrB} : addrA;
      sawData = useB ? wdataB : wdataA;
      stepCycle();
   endtask

   task automatic test_reset();
      rstA = 1'b0; rstB = 1'b0;
      validA = 0; lastA = 0; restartA = 0; opA = 0; rdA = 0; rs1A = 0; rs2A = 0; immA = 0;
      validB = 0; lastB = 0; restartB = 0; opB = 0; rdB = 0; rs1B = 0; rs2B = 0; immB = 0;
      stepCycle();
      stepCycle();
      totalChecks++;
      if ({readyA, weA, doneA, errFullA, errAlignA} !== 5'b10000) begin
         badChecks++;
         $display("[TB] FAIL reset_flags: got %b required 10000",
                  {readyA, weA, doneA, errFullA, errAlignA});
      end
      totalChecks++;
      if (addrA !== 8'd0 || countA !== 9'd0 || wdataA !== 32'd0) begin
         badChecks++;
         $display("[TB] FAIL reset_regs: got addr=%h count=%h wdata=%h required 0/0/0",
                  addrA, countA, wdataA);
      end
      totalChecks++;
      if ({readyB, weB, doneB, errFullB, errAlignB} !== 5'b10000) begin
         badChecks++;
         $display("[TB] FAIL reset_flags_b: got %b required 10000",
                  {readyB, weB, doneB, errFullB, errAlignB});
      end
      rstA = 1'b1; rstB = 1'b1;
      stepCycle();
   endtask

   task automatic test_addi();
      logic we; logic [7:0] a; logic [31:0] d;
      applyStimulus(1'b0, 2'b00, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0, we, a, d);
      totalChecks++;
      if (we !== 1'b1 || a !== 8'd0 || d !== 32'h00500093) begin
         badChecks++;
         $display("[TB] FAIL addi_write: got we=%b addr=%h wdata=%h required 1/00/00500093", we, a, d);
      end
      totalChecks++;
      if (countA !== 9'd1 || readyA !== 1'b1 || weA !== 1'b0 || addrA !== 8'd1) begin
         badChecks++;
         $display("[TB] FAIL addi_after: got count=%0d ready=%b we=%b addr=%0d required 1/1/0/1",
                  countA, readyA, weA, addrA);
      end
   endtask

   task automatic test_lw_sw();
      logic we; logic [7:0] a; logic [31:0] d;
      applyStimulus(1'b0, 2'b01, 5'd2, 5'd1, 5'd0, 13'd4, 1'b0, we, a, d);
      totalChecks++;
      if (we !== 1'b1 || a !== 8'd1 || d !== 32'h0040A103) begin
         badChecks++;
         $display("[TB] FAIL lw_write: got we=%b addr=%h wdata=%h required 1/01/0040A103", we, a, d);
      end
      applyStimulus(1'b0, 2'b10, 5'd0, 5'd0, 5'd2, 13'd8, 1'b0, we, a, d);
      totalChecks++;
      if (we !== 1'b1 || a !== 8'd2 || d !== 32'h00202423) begin
         badChecks++;
         $display("[TB] FAIL sw_write: got we=%b addr=%h wdata=%h required 1/02/00202423", we, a, d);
      end
      totalChecks++;
      if (countA !== 9'd3) begin
         badChecks++;
         $display("[TB] FAIL lw_sw_count: got %0d required 3", countA);
      end
   endtask

   task automatic test_bne_last();
      logic we; logic [7:0] a; logic [31:0] d;
      applyStimulus(1'b0, 2'b11, 5'd0, 5'd1, 5'd2, 13'h1FF8, 1'b1, we, a, d);
      totalChecks++;
      if (we !== 1'b1 || a !== 8'd3 || d !== 32'hFE209CE3) begin
         badChecks++;
         $display("[TB] FAIL bne_write: got we=%b addr=%h wdata=%h required 1/03/FE209CE3", we, a, d);
      end
      for (int i = 0; i < 4; i++) begin
         totalChecks++;
         if (doneA !== 1'b1 || readyA !== 1'b0 || countA !== 9'd4 || addrA !== 8'd3 || weA !== 1'b0) begin
            badChecks++;
            $display("[TB] FAIL done_hold: got done=%b ready=%b count=%0d addr=%0d we=%b required 1/0/4/3/0",
                     doneA, readyA, countA, addrA, weA);
         end
         stepCycle();
      end
      restartA = 1'b1;
      stepCycle();
      restartA = 1'b0;
      totalChecks++;
      if (readyA !== 1'b1 || addrA !== 8'd0 || countA !== 9'd0 || doneA !== 1'b0) begin
         badChecks++;
         $display("[TB] FAIL restart_done: got ready=%b addr=%0d count=%0d done=%b required 1/0/0/0",
                  readyA, addrA, countA, doneA);
      end
   endtask

   task automatic test_bne_misaligned();
      logic we; logic [7:0] a; logic [31:0] d;
      applyStimulus(1'b0, 2'b11, 5'd0, 5'd1, 5'd2, 13'h1FF9, 1'b0, we, a, d);
      totalChecks++;
      if (we !== 1'b1 || a !== 8'd0 || d !== 32'hFE209CE3) begin
         badChecks++;
         $display("[TB] FAIL bne_odd_write: got we=%b addr=%h wdata=%h required 1/00/FE209CE3", we, a, d);
      end
      totalChecks++;
      if (errAlignA !== 1'b1) begin
         badChecks++;
         $display("[TB] FAIL err_align_set: got %b required 1", errAlignA);
      end
      applyStimulus(1'b0, 2'b00, 5'd3, 5'd0, 5'd0, 13'd1, 1'b1, we, a, d);
      totalChecks++;
      if (errAlignA !== 1'b1 || doneA !== 1'b1 || a !== 8'd1 || d !== 32'h00100193) begin
         badChecks++;
         $display("[TB] FAIL err_align_hold: got align=%b done=%b addr=%h wdata=%h required 1/1/01/00100193",
                  errAlignA, doneA, a, d);
      end
      restartA = 1'b1;
      stepCycle();
      restartA = 1'b0;
      totalChecks++;
      if (errAlignA !== 1'b0 || readyA !== 1'b1) begin
         badChecks++;
         $display("[TB] FAIL err_align_clear: got align=%b ready=%b required 0/1", errAlignA, readyA);
      end
   endtask

   task automatic test_full();
      logic we; logic [7:0] a; logic [31:0] d;
      logic [31:0] expWord [4];
      expWord[0] = 32'h00100093;
      expWord[1] = 32'h00200113;
      expWord[2] = 32'h00300193;
      expWord[3] = 32'h00400213;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 2'b00, 5'(i + 1), 5'd0, 5'd0, 13'(i + 1), 1'b0, we, a, d);
         totalChecks++;
         if (we !== 1'b1 || a !== 8'(i) || d !== expWord[i]) begin
            badChecks++;
            $display("[TB] FAIL full_write%0d: got we=%b addr=%h wdata=%h required 1/%h/%h",
                     i, we, a, d, 8'(i), expWord[i]);
         end
      end
      totalChecks++;
      if (errFullB !== 1'b1 || readyB !== 1'b0 || countB !== 3'd4 || addrB !== 2'd3 || doneB !== 1'b0) begin
         badChecks++;
         $display("[TB] FAIL full_state: got full=%b ready=%b count=%0d addr=%0d done=%b required 1/0/4/3/0",
                  errFullB, readyB, countB, addrB, doneB);
      end
      opB = 2'b00; rdB = 5'd5; rs1B = 5'd0; rs2B = 5'd0; immB = 13'd5; lastB = 1'b0;
      validB = 1'b1;
      for (int i = 0; i < 8; i++) begin
         stepCycle();
         totalChecks++;
         if (readyB !== 1'b0 || weB !== 1'b0 || countB !== 3'd4) begin
            badChecks++;
            $display("[TB] FAIL full_reject: got ready=%b we=%b count=%0d required 0/0/4",
                     readyB, weB, countB);
         end
      end
      validB = 1'b0;
      restartB = 1'b1;
      stepCycle();
      restartB = 1'b0;
      totalChecks++;
      if (errFullB !== 1'b0 || readyB !== 1'b1 || countB !== 3'd0 || addrB !== 2'd0) begin
         badChecks++;
         $display("[TB] FAIL full_restart: got full=%b ready=%b count=%0d addr=%0d required 0/1/0/0",
                  errFullB, readyB, countB, addrB);
      end
   endtask

   task automatic test_reset_mid_cmd();
      logic we; logic [7:0] a; logic [31:0] d;
      applyStimulus(1'b0, 2'b11, 5'd0, 5'd1, 5'd2, 13'h1FF9, 1'b0, we, a, d);
      opA = 2'b00; rdA = 5'd7; rs1A = 5'd0; rs2A = 5'd0; immA = 13'd9; lastA = 1'b0;
      validA = 1'b1;
      stepCycle();
      validA = 1'b0;
      totalChecks++;
      if (readyA !== 1'b0 || weA !== 1'b0) begin
         badChecks++;
         $display("[TB] FAIL enc_state: got ready=%b we=%b required 0/0", readyA, weA);
      end
      rstA = 1'b0;
      stepCycle();
      totalChecks++;
      if ({readyA, weA, doneA, errFullA, errAlignA} !== 5'b10000 || addrA !== 8'd0 ||
          countA !== 9'd0 || wdataA !== 32'd0) begin
         badChecks++;
         $display("[TB] FAIL mid_reset: got flags=%b addr=%0d count=%0d wdata=%h required 10000/0/0/0",
                  {readyA, weA, doneA, errFullA, errAlignA}, addrA, countA, wdataA);
      end
      rstA = 1'b1;
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         totalChecks++;
         if (weA !== 1'b0 || readyA !== 1'b1) begin
            badChecks++;
            $display("[TB] FAIL discard: got we=%b ready=%b required 0/1", weA, readyA);
         end
      end
      applyStimulus(1'b0, 2'b00, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0, we, a, d);
      totalChecks++;
      if (we !== 1'b1 || a !== 8'd0 || d !== 32'h00500093 || countA !== 9'd1) begin
         badChecks++;
         $display("[TB] FAIL post_reset_cmd: got we=%b addr=%h wdata=%h count=%0d required 1/00/00500093/1",
                  we, a, d, countA);
      end
   endtask

   // Run all scenarios in order, then report
   initial begin
      test_reset();
      test_addi();
      test_lw_sw();
      test_bne_last();
      test_bne_misaligned();
      test_full();
      test_reset_mid_cmd();
      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

   // Guard against a stuck run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish, required finish before 100000 time units");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
